inst_buffer: RTL and testbench

INST_BUFFER -- requirements
Module: inst_buffer

---
 rtl/inst_buffer_pkg.sv | 20 ++
 rtl/ib_regfile.sv | 39 +++
 rtl/inst_buffer.sv | 105 ++++++++++
 tb/tb_inst_buffer.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/inst_buffer_pkg.sv
// Shared definitions for the instruction buffer: bus widths, default depth,
// the stored entry layout and a small pop-request helper.
package inst_buffer_pkg;

  localparam int unsigned InstBus     = 32;
  localparam int unsigned InstAddrBus = 32;
  localparam int unsigned IbDepth     = 16;

  // One buffered slot: PC in the upper half, instruction word in the lower half.
  typedef struct packed {
    logic [InstAddrBus-1:0] addr;
    logic [InstBus-1:0]     inst;
  } ib_entry_t;

  // Decode may request 3, which saturates to 2.
  function automatic logic [1:0] pop_request(input logic [1:0] pop_num);
    return (pop_num == 2'd3) ? 2'd2 : pop_num;
  endfunction

endpackage

// File: rtl/ib_regfile.sv
// Instruction buffer storage: DEPTH x 64-bit entries, two write ports and two
// asynchronous read ports. Contents are not reset; the owner masks reads by
// its occupancy count.
// Ports:
//   clk_i              clock
//   we1_i/we2_i        write enables (the two write addresses never collide)
//   waddr*_i/wdata*_i  write address/data
//   raddr*_i           read addresses
//   rdata*_o           combinational read data
module ib_regfile
  import inst_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = IbDepth,
  parameter int unsigned PTR_W = 4
) (
  input  logic             clk_i,
  input  logic             we1_i,
  input  logic [PTR_W-1:0] waddr1_i,
  input  ib_entry_t        wdata1_i,
  input  logic             we2_i,
  input  logic [PTR_W-1:0] waddr2_i,
  input  ib_entry_t        wdata2_i,
  input  logic [PTR_W-1:0] raddr1_i,
  input  logic [PTR_W-1:0] raddr2_i,
  output ib_entry_t        rdata1_o,
  output ib_entry_t        rdata2_o
);

  ib_entry_t mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we1_i) mem_q[waddr1_i] <= wdata1_i;
    if (we2_i) mem_q[waddr2_i] <= wdata2_i;
  end

  assign rdata1_o = mem_q[raddr1_i];
  assign rdata2_o = mem_q[raddr2_i];

endmodule

// File: rtl/inst_buffer.sv
// Instruction buffer between fetch and decode. Accepts up to two instructions
// per cycle from the ICache and presents the two oldest entries to decode.
// Ports:
//   aclk, aresetn                  clock, async active-low reset
//   flush_i                        discard all buffered entries
//   inst*_i, inst*_addr_i          pushed words and their PCs
//   inst*_valid_i                  push qualifiers (inst2 alone fills slot tail)
//   buffer_full_o                  fetch must not push next cycle
//   pop_num_i                      entries consumed by decode (3 acts as 2)
//   issue_inst*_o, issue_addr*_o   head / head+1 entries, zero when not valid
//   issue_valid*_o                 count >= 1 / count >= 2
module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = IbDepth,
  parameter int unsigned PTR_W = 4
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   flush_i,
  input  logic [InstBus-1:0]     inst1_i,
  input  logic [InstBus-1:0]     inst2_i,
  input  logic [InstAddrBus-1:0] inst1_addr_i,
  input  logic [InstAddrBus-1:0] inst2_addr_i,
  input  logic                   inst1_valid_i,
  input  logic                   inst2_valid_i,
  output logic                   buffer_full_o,
  input  logic [1:0]             pop_num_i,
  output logic [InstBus-1:0]     issue_inst1_o,
  output logic [InstBus-1:0]     issue_inst2_o,
  output logic [InstAddrBus-1:0] issue_addr1_o,
  output logic [InstAddrBus-1:0] issue_addr2_o,
  output logic                   issue_valid1_o,
  output logic                   issue_valid2_o
);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;

  logic [1:0]       push_num, pop_req, pop_eff;
  logic             push_ok;
  ib_entry_t        entry1, entry2, rd1, rd2;

  assign buffer_full_o = count_q > (PTR_W+1)'(DEPTH - 2);
  assign push_ok       = ~buffer_full_o & ~flush_i;
  assign push_num      = push_ok ? (2'(inst1_valid_i) + 2'(inst2_valid_i)) : 2'd0;

  // Clamp against the pre-edge count so an over-request never underflows.
  assign pop_req = pop_request(pop_num_i);
  assign pop_eff = ((PTR_W+1)'(pop_req) > count_q) ? count_q[1:0] : pop_req;

  // Valid words are packed from tail: inst2 alone takes slot tail.
  assign entry1 = inst1_valid_i ? '{addr: inst1_addr_i, inst: inst1_i}
                                : '{addr: inst2_addr_i, inst: inst2_i};
  assign entry2 = '{addr: inst2_addr_i, inst: inst2_i};

  ib_regfile #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_regfile (
    .clk_i    (aclk),
    .we1_i    (push_num != 2'd0),
    .waddr1_i (tail_q),
    .wdata1_i (entry1),
    .we2_i    (push_num == 2'd2),
    .waddr2_i (tail_q + PTR_W'(1)),
    .wdata2_i (entry2),
    .raddr1_i (head_q),
    .raddr2_i (head_q + PTR_W'(1)),
    .rdata1_o (rd1),
    .rdata2_o (rd2)
  );

  always_comb begin
    head_d  = head_q + PTR_W'(pop_eff);
    tail_d  = tail_q + PTR_W'(push_num);
    count_d = count_q + (PTR_W+1)'(push_num) - (PTR_W+1)'(pop_eff);
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign issue_valid1_o = count_q != '0;
  assign issue_valid2_o = count_q >= (PTR_W+1)'(2);
  assign issue_inst1_o  = issue_valid1_o ? rd1.inst : '0;
  assign issue_addr1_o  = issue_valid1_o ? rd1.addr : '0;
  assign issue_inst2_o  = issue_valid2_o ? rd2.inst : '0;
  assign issue_addr2_o  = issue_valid2_o ? rd2.addr : '0;

endmodule

// File: tb/tb_inst_buffer.sv
// Self-checking bench for inst_buffer: directed scenarios plus random traffic,
// compared against a queue-based model of the buffer contents.
module tb_inst_buffer;

  localparam int DEPTH = 16;
  localparam int PTR_W = 4;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] inst1_i = '0, inst2_i = '0, inst1_addr_i = '0, inst2_addr_i = '0;
  logic        inst1_valid_i = 1'b0, inst2_valid_i = 1'b0;
  logic [1:0]  pop_num_i = '0;
  logic        buffer_full_o, issue_valid1_o, issue_valid2_o;
  logic [31:0] issue_inst1_o, issue_inst2_o, issue_addr1_o, issue_addr2_o;

  logic [63:0] q[$];  // {addr, inst}, oldest first
  int total = 0;
  int bad = 0;
  logic [31:0] exp_pc;

  always #5 aclk = ~aclk;

  inst_buffer #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .flush_i        (flush_i),
    .inst1_i        (inst1_i),
    .inst2_i        (inst2_i),
    .inst1_addr_i   (inst1_addr_i),
    .inst2_addr_i   (inst2_addr_i),
    .inst1_valid_i  (inst1_valid_i),
    .inst2_valid_i  (inst2_valid_i),
    .buffer_full_o  (buffer_full_o),
    .pop_num_i      (pop_num_i),
    .issue_inst1_o  (issue_inst1_o),
    .issue_inst2_o  (issue_inst2_o),
    .issue_addr1_o  (issue_addr1_o),
    .issue_addr2_o  (issue_addr2_o),
    .issue_valid1_o (issue_valid1_o),
    .issue_valid2_o (issue_valid2_o)
  );

  task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // Compare every observable output (and the occupancy) against the model.
  task automatic check(input string tag);
    int n;
    n = q.size();
    cmp({tag, ".valid1"}, 32'(issue_valid1_o), 32'(n >= 1));
    cmp({tag, ".valid2"}, 32'(issue_valid2_o), 32'(n >= 2));
    cmp({tag, ".full"}, 32'(buffer_full_o), 32'(n > DEPTH - 2));
    cmp({tag, ".count"}, 32'(dut.count_q), 32'(n));
    cmp({tag, ".inst1"}, issue_inst1_o, (n >= 1) ? q[0][31:0] : 32'h0);
    cmp({tag, ".addr1"}, issue_addr1_o, (n >= 1) ? q[0][63:32] : 32'h0);
    cmp({tag, ".inst2"}, issue_inst2_o, (n >= 2) ? q[1][31:0] : 32'h0);
    cmp({tag, ".addr2"}, issue_addr2_o, (n >= 2) ? q[1][63:32] : 32'h0);
  endtask

  // Apply one cycle of stimulus, advance the model across the edge, check.
  task automatic step(input string tag, input logic fl, input logic v1, input logic [31:0] a1,
                      input logic v2, input logic [31:0] a2, input logic [1:0] pop);
    int n;
    bit full;
    flush_i = fl;
    inst1_valid_i = v1;
    inst2_valid_i = v2;
    inst1_addr_i = a1;
    inst2_addr_i = a2;
    inst1_i = $urandom;
    inst2_i = $urandom;
    pop_num_i = pop;
    @(posedge aclk);
    full = q.size() > DEPTH - 2;
    if (fl) begin
      q.delete();
    end else begin
      n = (pop == 2'd3) ? 2 : int'(pop);
      if (n > q.size()) n = q.size();
      repeat (n) void'(q.pop_front());
      if (!full) begin
        if (v1) q.push_back({a1, inst1_i});
        if (v2) q.push_back({a2, inst2_i});
      end
    end
    #1;
    check(tag);
  endtask

  initial begin
    // Reset state
    #2;
    check("reset");
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;

    // Asynchronous reset mid-stream with five entries held
    step("pre_rst", 0, 1, 32'h500, 1, 32'h504, 0);
    step("pre_rst", 0, 1, 32'h508, 1, 32'h50C, 0);
    step("pre_rst", 0, 1, 32'h510, 0, 32'h0, 0);
    #2;
    aresetn = 1'b0;
    q.delete();
    #1;
    check("rst_mid");
    @(negedge aclk);
    aresetn = 1'b1;
    step("rst_noop", 0, 0, 32'h0, 0, 32'h0, 0);

    // Fill at two per cycle with no pops until full; later pushes are dropped
    for (int i = 0; i < 10; i++) begin
      step("fill", 0, 1, 32'h1000 + 32'(8 * i), 1, 32'h1004 + 32'(8 * i), 0);
    end
    cmp("fill.full", 32'(buffer_full_o), 32'h1);
    cmp("fill.head1", issue_addr1_o, 32'h1000);
    cmp("fill.head2", issue_addr2_o, 32'h1004);
    // Pop while full with a push offered: pop proceeds, push ignored
    step("full_pop", 0, 1, 32'hDEAD0, 1, 32'hDEAD4, 2);

    // Steady push 2 / pop 2 across pointer wrap
    step("wrap_fl", 1, 0, 32'h0, 0, 32'h0, 0);
    step("wrap_pre", 0, 1, 32'h4000, 1, 32'h4004, 0);
    step("wrap_pre", 0, 1, 32'h4008, 1, 32'h400C, 0);
    exp_pc = 32'h4000;
    for (int i = 0; i < 20; i++) begin
      cmp("wrap.seq1", issue_addr1_o, exp_pc);
      cmp("wrap.seq2", issue_addr2_o, exp_pc + 32'h4);
      step("wrap", 0, 1, 32'h4010 + 32'(8 * i), 1, 32'h4014 + 32'(8 * i), 2);
      exp_pc = exp_pc + 32'h8;
      cmp("wrap.count", 32'(dut.count_q), 32'h4);
    end

    // Clamp: one entry, pop 2 requested, inst2-only push
    step("clamp_fl", 1, 0, 32'h0, 0, 32'h0, 0);
    step("clamp_pre", 0, 1, 32'h2000, 0, 32'h0, 0);
    step("clamp", 0, 0, 32'h0, 1, 32'h2004, 2);
    cmp("clamp.addr1", issue_addr1_o, 32'h2004);
    cmp("clamp.valid2", 32'(issue_valid2_o), 32'h0);

    // Flush overrides simultaneous push and pop
    for (int i = 0; i < 3; i++) begin
      step("fl_pre", 0, 1, 32'h6000 + 32'(8 * i), 1, 32'h6004 + 32'(8 * i), 0);
    end
    step("flush", 1, 1, 32'h7000, 1, 32'h7004, 2);
    cmp("flush.valid1", 32'(issue_valid1_o), 32'h0);
    step("post_fl", 0, 1, 32'h7100, 0, 32'h0, 0);
    cmp("post_fl.addr1", issue_addr1_o, 32'h7100);

    // Empty boundary: pop on empty with a single push
    step("empty_fl", 1, 0, 32'h0, 0, 32'h0, 0);
    step("empty", 0, 1, 32'h3000, 0, 32'h0, 1);
    cmp("empty.addr1", issue_addr1_o, 32'h3000);

    // Random traffic: push-heavy phase, then balanced with occasional flush
    for (int i = 0; i < 300; i++) begin
      step("rand", ($urandom_range(0, 39) == 0), 1'($urandom), $urandom, 1'($urandom),
           $urandom, (i < 120) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
